// File: rtl/valinor_sublist_reader.sv
// Valinor sublist reader: scans one sublist for the best eligible element,
// extracts it, compacts the sublist and reports the refreshed pointer.
package valinor_pkg;
    localparam int NUM_OF_ELEMENTS_PER_SUBLIST = 8;
    localparam int NUM_OF_SUBLIST = 16;
    localparam int TIME_W = 16;
    localparam int RANK_W = 16;
    localparam int EID_W  = 16;
    localparam int PNUM_W = $clog2(NUM_OF_ELEMENTS_PER_SUBLIST);
    localparam int PID_W  = $clog2(NUM_OF_SUBLIST);

    typedef logic [TIME_W-1:0] TIME_LOG;

    typedef struct packed {
        logic [EID_W-1:0]  id;
        logic [RANK_W-1:0] rank;
        TIME_LOG           send_time;
    } SublistElement;

    typedef struct packed {
        logic [PID_W-1:0]  id;
        logic              full;
        logic [PNUM_W-1:0] num;
        logic [RANK_W-1:0] smallest_rank;
        TIME_LOG           smallest_send_time;
    } PointerElement;
endpackage

module valinor_sublist_reader
    import valinor_pkg::*;
#(
    parameter int NUM_ELEMS    = NUM_OF_ELEMENTS_PER_SUBLIST,
    parameter int NUM_SUBLISTS = NUM_OF_SUBLIST,
    parameter int IDX_W        = $clog2(NUM_ELEMS),
    parameter int SL_W         = $clog2(NUM_SUBLISTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  PointerElement         req_ptr,
    input  TIME_LOG               req_now,
    output logic                  rd_en,
    output logic [SL_W+IDX_W-1:0] rd_addr,
    input  SublistElement         rd_data,
    output logic                  wr_en,
    output logic [SL_W+IDX_W-1:0] wr_addr,
    output SublistElement         wr_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_found,
    output SublistElement         resp_elem,
    output PointerElement         resp_ptr
);
    localparam int CNT_W = IDX_W + 1;
    localparam SublistElement CLR_ELEM = '{id: '0, rank: '1, send_time: '1};

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_WB_MOVE, S_WB_CLEAR, S_RESP
    } state_t;

    state_t r_state, w_next;

    logic              r_alive;
    PointerElement     r_ptr;
    TIME_LOG           r_now;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_slot;
    logic              r_dv;
    logic [IDX_W-1:0]  r_dslot;

    logic              r_bv, w_bv;
    logic [RANK_W-1:0] r_brank, w_brank;
    logic [IDX_W-1:0]  r_bslot, w_bslot;
    SublistElement     r_belem, w_belem;
    logic [RANK_W-1:0] r_m1r, w_m1r, r_m2r, w_m2r;
    logic [IDX_W-1:0]  r_m1s, w_m1s;
    TIME_LOG           r_t1, w_t1, r_t2, w_t2;
    logic [IDX_W-1:0]  r_t1s, w_t1s;
    SublistElement     r_last, w_last;

    logic              r_found;
    SublistElement     r_relem;
    PointerElement     r_rptr;

    logic              w_accept;
    logic [CNT_W-1:0]  w_req_cnt;
    logic [CNT_W-1:0]  w_cm1;
    logic [IDX_W-1:0]  w_last_idx;
    PointerElement     w_newptr;

    assign w_req_cnt  = req_ptr.full ? CNT_W'(NUM_ELEMS)
                                     : CNT_W'(req_ptr.num);
    assign w_cm1      = r_cnt - CNT_W'(1);
    assign w_last_idx = w_cm1[IDX_W-1:0];
    assign w_accept   = req_valid && req_ready;

    // Trackers fold in one returning element per cycle; slot 0 seeds the mins.
    always_comb begin
        w_bv    = r_bv;
        w_brank = r_brank;
        w_bslot = r_bslot;
        w_belem = r_belem;
        w_m1r   = r_m1r;
        w_m1s   = r_m1s;
        w_m2r   = r_m2r;
        w_t1    = r_t1;
        w_t1s   = r_t1s;
        w_t2    = r_t2;
        w_last  = r_last;
        if (r_dv) begin
            if (rd_data.send_time <= r_now &&
                (!r_bv || rd_data.rank < r_brank)) begin
                w_bv    = 1'b1;
                w_brank = rd_data.rank;
                w_bslot = r_dslot;
                w_belem = rd_data;
            end
            if (r_dslot == '0) begin
                w_m1r = rd_data.rank;
                w_m1s = r_dslot;
                w_m2r = '1;
                w_t1  = rd_data.send_time;
                w_t1s = r_dslot;
                w_t2  = '1;
            end else begin
                if (rd_data.rank < r_m1r) begin
                    w_m2r = r_m1r;
                    w_m1r = rd_data.rank;
                    w_m1s = r_dslot;
                end else if (rd_data.rank < r_m2r) begin
                    w_m2r = rd_data.rank;
                end
                if (rd_data.send_time < r_t1) begin
                    w_t2  = r_t1;
                    w_t1  = rd_data.send_time;
                    w_t1s = r_dslot;
                end else if (rd_data.send_time < r_t2) begin
                    w_t2 = rd_data.send_time;
                end
            end
            if (r_dslot == w_last_idx) w_last = rd_data;
        end
    end

    always_comb begin
        w_newptr      = r_ptr;
        w_newptr.full = 1'b0;
        w_newptr.num  = PNUM_W'(w_cm1);
        if (w_cm1 == '0) begin
            w_newptr.smallest_rank      = '1;
            w_newptr.smallest_send_time = '1;
        end else begin
            w_newptr.smallest_rank =
                (w_m1s == w_bslot) ? w_m2r : w_m1r;
            w_newptr.smallest_send_time =
                (w_t1s == w_bslot) ? w_t2 : w_t1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = r_alive;
                if (w_accept)
                    w_next = (w_req_cnt == '0) ? S_RESP : S_SCAN;
            end
            S_SCAN: begin
                rd_en   = 1'b1;
                rd_addr = {r_ptr.id[SL_W-1:0], r_slot};
                if (r_slot == w_last_idx) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!w_bv)                         w_next = S_RESP;
                else if (w_bslot == w_last_idx)    w_next = S_WB_CLEAR;
                else                               w_next = S_WB_MOVE;
            end
            S_WB_MOVE: begin
                wr_en   = 1'b1;
                wr_addr = {r_ptr.id[SL_W-1:0], r_bslot};
                wr_data = r_last;
                w_next  = S_WB_CLEAR;
            end
            S_WB_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = {r_ptr.id[SL_W-1:0], w_last_idx};
                wr_data = CLR_ELEM;
                w_next  = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
            r_ptr   <= '0;
            r_now   <= '0;
            r_cnt   <= '0;
            r_slot  <= '0;
            r_dv    <= 1'b0;
            r_dslot <= '0;
            r_bv    <= 1'b0;
            r_brank <= '0;
            r_bslot <= '0;
            r_belem <= '0;
            r_m1r   <= '0;
            r_m1s   <= '0;
            r_m2r   <= '0;
            r_t1    <= '0;
            r_t1s   <= '0;
            r_t2    <= '0;
            r_last  <= '0;
            r_found <= 1'b0;
            r_relem <= '0;
            r_rptr  <= '0;
        end else begin
            r_alive <= 1'b1;
            r_dv    <= (r_state == S_SCAN);
            r_dslot <= r_slot;
            r_bv    <= w_bv;
            r_brank <= w_brank;
            r_bslot <= w_bslot;
            r_belem <= w_belem;
            r_m1r   <= w_m1r;
            r_m1s   <= w_m1s;
            r_m2r   <= w_m2r;
            r_t1    <= w_t1;
            r_t1s   <= w_t1s;
            r_t2    <= w_t2;
            r_last  <= w_last;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ptr   <= req_ptr;
                        r_now   <= req_now;
                        r_cnt   <= w_req_cnt;
                        r_slot  <= '0;
                        r_bv    <= 1'b0;
                        r_found <= 1'b0;
                        r_relem <= '0;
                        r_rptr  <= req_ptr;
                    end
                end
                S_SCAN:  r_slot <= r_slot + IDX_W'(1);
                S_DRAIN: begin
                    r_found <= w_bv;
                    r_relem <= w_bv ? w_belem : '0;
                    r_rptr  <= w_bv ? w_newptr : r_ptr;
                end
                default: ;
            endcase
        end
    end

    assign resp_found = r_found;
    assign resp_elem  = r_relem;
    assign resp_ptr   = r_rptr;

endmodule

// File: tb/tb_valinor_sublist_reader.sv
// Bench for valinor_sublist_reader: directed and random requests checked
// against a list-level model of extraction and compaction.
module tb_valinor_sublist_reader;
    import valinor_pkg::*;

    localparam int NE = 8;
    localparam int NS = 16;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    PointerElement req_ptr = '0;
    TIME_LOG       req_now = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    SublistElement rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    SublistElement wr_data;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_found;
    SublistElement resp_elem;
    PointerElement resp_ptr;

    always #5 clk = ~clk;

    valinor_sublist_reader dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ptr(req_ptr), .req_now(req_now),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_found(resp_found), .resp_elem(resp_elem),
        .resp_ptr(resp_ptr)
    );

    SublistElement mem [0:NS*NE-1];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    SublistElement ld_data = '0;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    int n_rd = 0, n_wr = 0, n_both = 0;
    always @(posedge clk) begin
        if (rd_en) n_rd <= n_rd + 1;
        if (wr_en) n_wr <= n_wr + 1;
        if (rd_en && wr_en) n_both <= n_both + 1;
    end

    int ncmp = 0;
    int nerr = 0;
    SublistElement el [0:NE-1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_sub(input int sl);
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            ld_en = 1'b1;
            ld_addr = AW'(sl * NE + k);
            ld_data = el[k];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic rnd_elems(input int rmax, input int tmax);
        for (int k = 0; k < NE; k++) begin
            el[k].id        = EID_W'($urandom);
            el[k].rank      = RANK_W'($urandom_range(0, rmax));
            el[k].send_time = TIME_W'($urandom_range(0, tmax));
        end
    endtask

    task automatic run(input int sl, input bit full, input int num,
                       input int now, input int hold);
        PointerElement p, exp_p;
        SublistElement exp_e;
        SublistElement after [0:NE-1];
        logic [RANK_W-1:0] mr;
        TIME_LOG mt;
        int cnt, win, lat, exp_lat, exp_w, r0, w0, b0;
        bit found;
        load_sub(sl);
        p.id = PID_W'(sl);
        p.full = full;
        p.num = PNUM_W'(num);
        p.smallest_rank = RANK_W'($urandom);
        p.smallest_send_time = TIME_W'($urandom);
        cnt = full ? NE : num;
        found = 0;
        win = 0;
        for (int k = 0; k < cnt; k++)
            if (el[k].send_time <= TIME_W'(now) &&
                (!found || el[k].rank < el[win].rank)) begin
                found = 1;
                win = k;
            end
        for (int k = 0; k < NE; k++) after[k] = el[k];
        mr = '1;
        mt = '1;
        for (int k = 0; k < cnt; k++)
            if (!(found && k == win)) begin
                if (el[k].rank < mr) mr = el[k].rank;
                if (el[k].send_time < mt) mt = el[k].send_time;
            end
        if (found) begin
            after[win] = el[cnt-1];
            after[cnt-1] = '{id: '0, rank: '1, send_time: '1};
            exp_p = '{id: p.id, full: 1'b0, num: PNUM_W'(cnt-1),
                      smallest_rank: mr, smallest_send_time: mt};
            exp_e = el[win];
            exp_w = (win == cnt-1) ? 1 : 2;
            exp_lat = (win == cnt-1) ? cnt + 3 : cnt + 4;
        end else begin
            exp_p = p;
            exp_e = '0;
            exp_w = 0;
            exp_lat = (cnt == 0) ? 1 : cnt + 2;
        end
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_ptr = p;
        req_now = TIME_W'(now);
        resp_ready = 1'b0;
        r0 = n_rd; w0 = n_wr; b0 = n_both;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        chk("resp_latency", lat, exp_lat);
        if (lat != 0) begin
            for (int h = 0; h < hold; h++) begin
                chk("hold_valid", resp_valid, 1);
                chk("hold_req_ready", req_ready, 0);
                chk("hold_elem", resp_elem, exp_e);
                chk("hold_ptr", resp_ptr, exp_p);
                @(negedge clk);
            end
            chk("resp_found", resp_found, found);
            chk("resp_elem", resp_elem, exp_e);
            chk("resp_ptr", resp_ptr, exp_p);
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            chk("resp_drop", resp_valid, 0);
            chk("req_ready_after", req_ready, 1);
        end
        chk("read_count", n_rd - r0, cnt);
        chk("write_count", n_wr - w0, exp_w);
        chk("rd_wr_overlap", n_both - b0, 0);
        for (int k = 0; k < NE; k++)
            chk("ram_slot", mem[sl*NE+k], after[k]);
    endtask

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_found", resp_found, 0);
        chk("rst_resp_ptr", resp_ptr, 0);
        chk("rst_resp_elem", resp_elem, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        rnd_elems(15, 63);
        run(3, 0, 0, 10, 0);

        rnd_elems(15, 63);
        el[0] = '{id: 16'h00a0, rank: 5, send_time: 0};
        el[1] = '{id: 16'h00a1, rank: 2, send_time: 0};
        el[2] = '{id: 16'h00a2, rank: 9, send_time: 0};
        run(1, 0, 3, 10, 0);

        for (int k = 0; k < NE; k++)
            el[k] = '{id: EID_W'(16'h0b00 + k),
                      rank: RANK_W'(10 + k), send_time: TIME_W'(k)};
        el[7].rank = 1;
        run(7, 1, 2, 20, 0);

        rnd_elems(15, 63);
        el[0] = '{id: 16'h0c00, rank: 1, send_time: 50};
        el[1] = '{id: 16'h0c01, rank: 4, send_time: 5};
        el[2] = '{id: 16'h0c02, rank: 8, send_time: 60};
        run(2, 0, 3, 20, 0);

        for (int k = 0; k < NE; k++)
            el[k] = '{id: EID_W'(16'h0d00 + k), rank: 9, send_time: 0};
        el[2].rank = 3;
        el[5].rank = 3;
        run(4, 0, 6, 0, 0);

        rnd_elems(15, 63);
        for (int k = 0; k < NE; k++) el[k].send_time = TIME_W'(30 + k);
        run(5, 0, 5, 29, 0);

        rnd_elems(15, 63);
        for (int k = 0; k < NE; k++) el[k].send_time = 0;
        run(6, 0, 4, 5, 5);

        rnd_elems(15, 63);
        load_sub(9);
        @(negedge clk);
        req_valid = 1'b1;
        req_ptr = '{id: 9, full: 1'b1, num: 0,
                    smallest_rank: 0, smallest_send_time: 0};
        req_now = 100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        w0 = n_wr;
        @(negedge clk);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_resp_ptr", resp_ptr, 0);
        chk("mid_rst_resp_elem", resp_elem, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("mid_rst_no_write", n_wr - w0, 0);
        chk("mid_rst_idle", req_ready, 1);
        for (int k = 0; k < NE; k++)
            chk("mid_rst_ram", mem[9*NE+k], el[k]);

        for (int t = 0; t < 30; t++) begin
            int cn;
            rnd_elems(15, 63);
            cn = $urandom_range(0, NE);
            run($urandom_range(0, NS-1), cn == NE, (cn == NE) ? $urandom_range(0, NE-1) : cn,
                $urandom_range(0, 70), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/valinor_sublist_reader.md
# valinor_sublist_reader

Read/extract engine for one Valinor sublist: the consumer end of the sublist storage that the insert path writes. On a request it scans the sublist's `SublistElement` slots from sublist RAM, selects the smallest-rank element whose `send_time` is not later than the current time, and returns it. It compacts the sublist by moving the last element into the vacated slot, and emits the refreshed `PointerElement` for the pointer array. It sits between the top-level dequeue controller and the sublist RAM.

## Interface
- `NUM_ELEMS`, 8: slots per sublist (`NUM_OF_ELEMENTS_PER_SUBLIST`).
- `NUM_SUBLISTS`, 16: sublists in RAM (`NUM_OF_SUBLIST`).
- `IDX_W`, `$clog2(NUM_ELEMS)`: slot index width.
- `SL_W`, `$clog2(NUM_SUBLISTS)`: sublist id width.
- `clk`  in  1  clock.
- `rst_n`  in  1  **synchronous, active-low reset; one clock; all state updates on rising `clk`**.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  engine idle, can accept.
- `req_ptr`  in  `PointerElement`  current metadata of the target sublist (id, full, num).
- `req_now`  in  `TIME_LOG`  current time.
- `rd_en`  out  1  RAM read strobe.
- `rd_addr`  out  `SL_W+IDX_W`  `{sublist id, slot}`.
- `rd_data`  in  `SublistElement`  read data, valid the cycle after `rd_en`.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  `SL_W+IDX_W`  write address.
- `wr_data`  out  `SublistElement`  write data.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts response.
- `resp_found`  out  1  an eligible element was extracted.
- `resp_elem`  out  `SublistElement`  extracted element (zero if not found).
- `resp_ptr`  out  `PointerElement`  updated sublist metadata.

## Operation
- Element count `cnt = full ? NUM_ELEMS : num`. Valid slots are 0..cnt-1. Infinity means all ones.
- Eligible: `send_time <= req_now`, unsigned compare, no wrap handling.
- The FSM has states IDLE, SCAN, DRAIN, WB_MOVE, WB_CLEAR and RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch `req_ptr` and `req_now`. If `cnt==0`, go to RESP with found=0. Otherwise go to SCAN.
- SCAN: issue `rd_en` for slots 0..cnt-1, one per cycle. Go to DRAIN after the last read is issued.
- Each returning `rd_data` for slot k updates the tracking registers:
  - Best eligible: rank, slot, element. Uses strict `<`, so on ties the lowest slot wins.
  - Overall min rank and second-min rank, each with its slot.
  - Overall min send_time and second-min send_time, each with its slot.
  - The element from slot cnt-1, kept as the last element.
- DRAIN: consume the final `rd_data`.
  - If none eligible, go to RESP.
  - Else if winner slot == cnt-1, go to WB_CLEAR.
  - Else go to WB_MOVE.
- WB_MOVE: write the last element to the winner slot.
- WB_CLEAR: write `{id:0, rank:'1, send_time:'1}` to slot cnt-1.
- RESP: hold `resp_valid` and all `resp_*` stable until `resp_ready`, then return to IDLE.
- `resp_ptr` when found:
  - `id` unchanged, `full=0`, `num = cnt-1` (low bits).
  - `smallest_rank` = second-min rank if the min-rank slot is the winner, else min rank.
  - `smallest_send_time` is derived from the send_time tracker by the same rule.
  - Both fields are infinity if `cnt-1==0`.
- `resp_ptr` when not found: identical to the latched `req_ptr`. No RAM writes occur.

## Timing
- Reset values:
  - `req_ready=0`, then 1 from the first cycle after `rst_n` rises.
  - `rd_en`, `wr_en`, `resp_valid`, `resp_found` are 0.
  - All address, data, `resp_elem` and `resp_ptr` outputs are 0.
- Acceptance cycle = 0.
- Reads occur in cycles 1..cnt, with `rd_addr` slot = cycle-1. Data arrives in cycles 2..cnt+1.
- `resp_valid` first asserts in:
  - cycle cnt+4 if found and moved;
  - cycle cnt+3 if found and the winner is the last slot;
  - cycle cnt+2 if not found;
  - cycle 1 if `cnt==0`.
- `wr_en` is high for exactly one cycle per write state. At most one read and one write per cycle, and never both in the same cycle.
- `req_ready=0` in every state but IDLE. Back-to-back requests are possible the cycle after the handshake.
- Reset mid-operation: abort at the next edge. No further RAM writes, `resp_valid` drops, return to IDLE. A partially compacted sublist is the controller's responsibility.

## Test plan
- Empty sublist (`full=0,num=0`) -> `resp_valid` in cycle 1; found=0; no `rd_en`/`wr_en`; `resp_ptr` == `req_ptr`.
- cnt=3, ranks {5,2,9}, all send_time 0, now=10 -> returns slot-1 element.
  - Writes: slot 1 <= slot-2 element, then slot 2 <= infinity.
  - `resp_ptr.num=2`, `smallest_rank=5`, `resp_valid` in cycle 7.
- Full sublist (8 slots), winner in slot 7 -> no WB_MOVE; single clear write to slot 7.
  - `full=0`, `num=7`, `resp_valid` in cycle 11.
- Min-rank element ineligible (rank 1, send_time 50, now 20); rank-4 element eligible -> rank 4 returned; `smallest_rank=1` and `smallest_send_time=50` retained.
- Ties: equal rank 3 in slots 2 and 5, both eligible -> slot 2 returned.
- No element eligible -> found=0, no writes, `resp_ptr` == `req_ptr`.
- Hold `resp_ready=0` for 5 cycles -> `resp_*` stable; `req_ready` stays 0.
- Reset asserted during SCAN -> no writes afterward; outputs return to reset values.
